// File: rtl/wb_write_arbiter_if.sv
// Register-file write-port bundle for wb_write_arbiter.
//   Request side : wb_valid/wb_reg/wb_data (pipeline writeback),
//                  lu_valid/lu_ready/lu_reg/lu_data (long-latency results),
//                  issue_valid/issue_reg (long-latency op issued).
//   Status side  : busy_vec (pending-destination scoreboard), fifo_count.
//   Write side   : RegWrite/writeReg/writeData (registered, sampled by the
//                  register file on the falling edge).
// Handshake: a long-latency result transfers on a rising edge where
// lu_valid && lu_ready; lu_valid may be raised independently of lu_ready,
// and lu_ready never depends on lu_valid. The pipeline writeback has no
// ready: it is always accepted.
// Modports: master = result producers / hazard unit; slave = the arbiter.
interface wb_write_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  logic                    wb_valid;
  logic [AW-1:0]           wb_reg;
  logic [DW-1:0]           wb_data;
  logic                    lu_valid;
  logic                    lu_ready;
  logic [AW-1:0]           lu_reg;
  logic [DW-1:0]           lu_data;
  logic                    issue_valid;
  logic [AW-1:0]           issue_reg;
  logic [2**AW-1:0]        busy_vec;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    RegWrite;
  logic [AW-1:0]           writeReg;
  logic [DW-1:0]           writeData;

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    input  lu_valid, lu_reg, lu_data,
    input  issue_valid, issue_reg,
    output lu_ready, busy_vec, fifo_count,
    output RegWrite, writeReg, writeData
  );

  modport master (
    output wb_valid, wb_reg, wb_data,
    output lu_valid, lu_reg, lu_data,
    output issue_valid, issue_reg,
    input  lu_ready, busy_vec, fifo_count,
    input  RegWrite, writeReg, writeData
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: drives the single register-file write port.
// Pipeline writebacks have strict priority; long-latency results wait in a
// DEPTH-entry FIFO and drain into idle writeback slots. A busy scoreboard
// marks destinations of issued long-latency ops until their result retires.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous, active-high reset (also forces lu_ready low)
//   bus - wb_write_arbiter_if.slave (request, status and write signals)
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  wb_write_arbiter_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 2**AW;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // FIFO storage (no reset needed: validity is tracked by count_q)
  logic [AW-1:0] reg_mem_q  [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [NR-1:0] busy_q,   busy_d;
  logic          reg_write_q,  reg_write_d;
  logic [AW-1:0] write_reg_q,  write_reg_d;
  logic [DW-1:0] write_data_q, write_data_d;

  logic          lu_ready;
  logic          push;
  logic          pop;
  logic          wb_take;
  logic [AW-1:0] head_reg;
  logic [DW-1:0] head_data;

  // Full is judged on the registered count, so a pop in the same cycle
  // does not open a slot for a push.
  assign lu_ready  = !rst && (count_q < FULL_COUNT);
  assign push      = bus.lu_valid && lu_ready;
  // A writeback to reg 0 is dropped and leaves the slot free for the FIFO.
  assign wb_take   = bus.wb_valid && (bus.wb_reg != '0);
  // Using the registered count means an entry pushed into an empty FIFO
  // cannot be popped on the same edge (no bypass).
  assign pop       = !wb_take && (count_q != '0);
  assign head_reg  = reg_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (wb_take) begin
      reg_write_d  = 1'b1;
      write_reg_d  = bus.wb_reg;
      write_data_d = bus.wb_data;
    end else if (pop) begin
      // A reg-0 head still retires, just without a write strobe.
      reg_write_d  = (head_reg != '0);
      write_reg_d  = head_reg;
      write_data_d = head_data;
    end
  end

  // Clear first, then set, so an issue colliding with a retirement to the
  // same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (pop && (head_reg != '0)) busy_d[head_reg] = 1'b0;
    if (bus.issue_valid && (bus.issue_reg != '0)) busy_d[bus.issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem_q[wr_ptr_q]  <= bus.lu_reg;
      data_mem_q[wr_ptr_q] <= bus.lu_data;
    end
  end

  assign bus.lu_ready   = lu_ready;
  assign bus.fifo_count = count_q;
  assign bus.busy_vec   = busy_q;
  assign bus.RegWrite   = reg_write_q;
  assign bus.writeReg   = write_reg_q;
  assign bus.writeData  = write_data_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int EW    = 16 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] cyc_q = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_q <= cyc_q + 16'd1;

  wb_write_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus();

  wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected writes: {edge number at which outputs show it, reg, data}
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] mk(input logic [15:0] c,
                                       input logic [AW-1:0] r,
                                       input logic [DW-1:0] d);
    return {c, r, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc_q);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid    = 1'b0;
    bus.lu_valid    = 1'b0;
    bus.issue_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d writes still outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    while (exp_q.size() != 0 && exp_q[0][EW-1:AW+DW] < cyc_q) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write: reg %0d data 0x%0h due cycle %0d not seen",
               e[AW+DW-1:DW], e[DW-1:0], e[EW-1:AW+DW]);
    end
    if (exp_q.size() != 0 && exp_q[0][EW-1:AW+DW] == cyc_q) begin
      e = exp_q.pop_front();
      checks++;
      if (!(bus.RegWrite === 1'b1 && bus.writeReg === e[AW+DW-1:DW] &&
            bus.writeData === e[DW-1:0])) begin
        errors++;
        $display("FAIL write_port: got we=%0b reg=%0d data=0x%0h, required we=1 reg=%0d data=0x%0h (cycle %0d)",
                 bus.RegWrite, bus.writeReg, bus.writeData,
                 e[AW+DW-1:DW], e[DW-1:0], cyc_q);
      end
    end else if (bus.RegWrite !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write: got we=%0b reg=%0d data=0x%0h, required no write (cycle %0d)",
               bus.RegWrite, bus.writeReg, bus.writeData, cyc_q);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] k0;
    bus.wb_reg = '0; bus.wb_data = '0;
    bus.lu_reg = '0; bus.lu_data = '0;
    bus.issue_reg = '0;
    idle();

    // Reset: two cycles held, then released with no stimulus
    rst = 1'b1;
    #1;
    check("lu_ready_in_reset", 64'(bus.lu_ready), 64'd0);
    tick();
    tick();
    check("rst_regwrite",   64'(bus.RegWrite),   64'd0);
    check("rst_writereg",   64'(bus.writeReg),   64'd0);
    check("rst_writedata",  64'(bus.writeData),  64'd0);
    check("rst_busy",       64'(bus.busy_vec),   64'd0);
    check("rst_count",      64'(bus.fifo_count), 64'd0);
    check("lu_ready_rst2",  64'(bus.lu_ready),   64'd0);
    rst = 1'b0;
    #1;
    check("lu_ready_after_rst", 64'(bus.lu_ready), 64'd1);
    tick();

    // Pipeline only; also issue to reg 0, which must never become busy
    bus.wb_valid = 1'b1; bus.wb_reg = 5'd3; bus.wb_data = 32'hDEAD_BEEF;
    bus.issue_valid = 1'b1; bus.issue_reg = 5'd0;
    exp_q.push_back(mk(cyc_q + 16'd1, 5'd3, 32'hDEAD_BEEF));
    tick();
    idle();
    check("wb_we",      64'(bus.RegWrite),  64'd1);
    check("wb_reg",     64'(bus.writeReg),  64'd3);
    check("wb_data",    64'(bus.writeData), 64'hDEAD_BEEF);
    check("busy_reg0",  64'(bus.busy_vec),  64'd0);
    tick();
    check("wb_we_drop", 64'(bus.RegWrite),  64'd0);
    check("wb_hold_reg", 64'(bus.writeReg), 64'd3);
    check("wb_hold_data", 64'(bus.writeData), 64'hDEAD_BEEF);

    // Long-latency path
    bus.issue_valid = 1'b1; bus.issue_reg = 5'd7;
    tick();
    idle();
    check("ll_busy_set", 64'(bus.busy_vec[7]), 64'd1);
    tick();
    bus.lu_valid = 1'b1; bus.lu_reg = 5'd7; bus.lu_data = 32'h1234_5678;
    exp_q.push_back(mk(cyc_q + 16'd2, 5'd7, 32'h1234_5678));
    tick();
    idle();
    check("ll_count1",     64'(bus.fifo_count),  64'd1);
    check("ll_busy_hold",  64'(bus.busy_vec[7]), 64'd1);
    check("ll_no_bypass",  64'(bus.RegWrite),    64'd0);
    tick();
    check("ll_count0",     64'(bus.fifo_count),  64'd0);
    check("ll_we",         64'(bus.RegWrite),    64'd1);
    check("ll_reg",        64'(bus.writeReg),    64'd7);
    check("ll_busy_clear", 64'(bus.busy_vec[7]), 64'd0);
    drain();

    // Priority / starvation: fill FIFO under continuous pipeline writebacks
    k0 = cyc_q;
    for (int i = 0; i < 5; i++) begin
      bus.wb_valid = 1'b1; bus.wb_reg = 5'(10 + i); bus.wb_data = 32'hB000 + 32'(i);
      bus.lu_valid = (i < 4); bus.lu_reg = 5'(i + 1); bus.lu_data = 32'hC000 + 32'(i + 1);
      exp_q.push_back(mk(cyc_q + 16'd1, 5'(10 + i), 32'hB000 + 32'(i)));
      if (i == 0) check("prio_ready_empty", 64'(bus.lu_ready), 64'd1);
      if (i == 4) check("prio_ready_full",  64'(bus.lu_ready), 64'd0);
      tick();
    end
    check("prio_cycles", 64'(cyc_q - k0), 64'd5);
    check("prio_count4", 64'(bus.fifo_count), 64'd4);
    for (int j = 0; j < 4; j++)
      exp_q.push_back(mk(cyc_q + 16'(1 + j), 5'(j + 1), 32'hC000 + 32'(j + 1)));
    // Offer a result while full and popping: it must be refused
    bus.wb_valid = 1'b0;
    bus.lu_valid = 1'b1; bus.lu_reg = 5'd6; bus.lu_data = 32'hEEEE;
    check("full_pop_ready", 64'(bus.lu_ready), 64'd0);
    tick();
    idle();
    check("full_pop_count3", 64'(bus.fifo_count), 64'd3);
    drain();
    tick();
    check("prio_count_end", 64'(bus.fifo_count), 64'd0);

    // Register 0 handling: dropped wb does not block the FIFO pop
    bus.issue_valid = 1'b1; bus.issue_reg = 5'd5;
    bus.lu_valid = 1'b1; bus.lu_reg = 5'd5; bus.lu_data = 32'hA;
    tick();
    idle();
    check("r0_count1", 64'(bus.fifo_count), 64'd1);
    check("r0_busy5",  64'(bus.busy_vec),   64'h20);
    bus.wb_valid = 1'b1; bus.wb_reg = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
    exp_q.push_back(mk(cyc_q + 16'd1, 5'd5, 32'hA));
    tick();
    idle();
    check("r0_we5",     64'(bus.RegWrite), 64'd1);
    check("r0_reg5",    64'(bus.writeReg), 64'd5);
    check("r0_busy5_clr", 64'(bus.busy_vec), 64'd0);
    bus.issue_valid = 1'b1; bus.issue_reg = 5'd6;
    bus.lu_valid = 1'b1; bus.lu_reg = 5'd0; bus.lu_data = 32'hB;
    tick();
    idle();
    check("r0_busy6", 64'(bus.busy_vec), 64'h40);
    tick();
    check("r0_pop_we",    64'(bus.RegWrite),   64'd0);
    check("r0_pop_reg",   64'(bus.writeReg),   64'd0);
    check("r0_pop_data",  64'(bus.writeData),  64'hB);
    check("r0_pop_busy",  64'(bus.busy_vec),   64'h40);
    check("r0_pop_count", 64'(bus.fifo_count), 64'd0);
    drain();

    // Reset mid-operation with three entries queued
    for (int i = 0; i < 3; i++) begin
      bus.wb_valid = 1'b1; bus.wb_reg = 5'(13 + i); bus.wb_data = 32'hD000 + 32'(i);
      bus.lu_valid = 1'b1; bus.lu_reg = 5'(20 + i); bus.lu_data = 32'hE000 + 32'(i);
      bus.issue_valid = 1'b1; bus.issue_reg = 5'(20 + i);
      exp_q.push_back(mk(cyc_q + 16'd1, 5'(13 + i), 32'hD000 + 32'(i)));
      tick();
    end
    idle();
    check("mid_count3", 64'(bus.fifo_count), 64'd3);
    check("mid_busy",   64'(bus.busy_vec),   64'h0070_0040);
    rst = 1'b1;
    #1;
    check("mid_ready_rst", 64'(bus.lu_ready), 64'd0);
    tick();
    rst = 1'b0;
    check("mid_count0", 64'(bus.fifo_count), 64'd0);
    check("mid_busy0",  64'(bus.busy_vec),   64'd0);
    check("mid_we0",    64'(bus.RegWrite),   64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_write", 64'(bus.RegWrite), 64'd0);
    end

    // Set wins over clear on the same register
    bus.issue_valid = 1'b1; bus.issue_reg = 5'd9;
    tick();
    idle();
    check("sw_busy_set", 64'(bus.busy_vec[9]), 64'd1);
    bus.lu_valid = 1'b1; bus.lu_reg = 5'd9; bus.lu_data = 32'h99;
    exp_q.push_back(mk(cyc_q + 16'd2, 5'd9, 32'h99));
    tick();
    idle();
    bus.issue_valid = 1'b1; bus.issue_reg = 5'd9;
    tick();
    idle();
    check("sw_we",       64'(bus.RegWrite),    64'd1);
    check("sw_busy_kept", 64'(bus.busy_vec[9]), 64'd1);
    bus.lu_valid = 1'b1; bus.lu_reg = 5'd9; bus.lu_data = 32'h9A;
    exp_q.push_back(mk(cyc_q + 16'd2, 5'd9, 32'h9A));
    tick();
    idle();
    tick();
    check("sw_busy_clear", 64'(bus.busy_vec[9]), 64'd0);
    drain();

    tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Initiator side of the register-file write port: produces the single RegWrite/writeReg/writeData triple that the register file samples on the falling clock edge.
- Merges two result sources:
  - in-order pipeline writeback, which is always accepted;
  - results from a long-latency unit (mult/div), buffered in a small FIFO.
- Keeps a per-register busy scoreboard so hazard logic can stall readers of pending destinations.

Parameters:
DEPTH, 4, entries in the long-latency result FIFO (power of 2, >=2)
AW, 5, register address width
DW, 32, register data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
wb_valid  in  1  pipeline writeback request this cycle
wb_reg  in  AW  pipeline destination register
wb_data  in  DW  pipeline result
lu_valid  in  1  long-latency result offered
lu_ready  out  1  FIFO can accept; transfer when lu_valid && lu_ready
lu_reg  in  AW  long-latency destination register
lu_data  in  DW  long-latency result
issue_valid  in  1  long-latency op issued this cycle
issue_reg  in  AW  destination of issued op
busy_vec  out  2**AW  scoreboard; bit n = reg n has a pending long-latency write
fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy
RegWrite  out  1  register-file write enable (registered)
writeReg  out  AW  register-file write address (registered)
writeData  out  DW  register-file write data (registered)

Behaviour:
- Reset: synchronous, active-high. All of the following are cleared on the next rising edge while rst=1:
  - RegWrite=0, writeReg=0, writeData=0;
  - busy_vec=0;
  - FIFO emptied, fifo_count=0.
- lu_ready=0 while rst=1.
- Reset mid-operation discards all queued FIFO entries and pending busy bits with no write.
- lu_ready = !rst && (fifo_count < DEPTH), combinational.
- Push: on lu_valid && lu_ready, {lu_reg, lu_data} is written at the tail.
- No bypass: an accepted lu result reaches the RegWrite outputs at the earliest 2 cycles after acceptance (enter FIFO, pop, output register).
- Arbitration is evaluated each cycle; the registered outputs update on the next edge:
  - wb_valid && wb_reg!=0: outputs <= {1, wb_reg, wb_data}; no FIFO pop. Pipeline has strict priority.
  - Otherwise, FIFO non-empty: pop head; outputs <= {head_reg!=0, head_reg, head_data}. A head entry with reg 0 is popped with RegWrite=0.
  - Otherwise: RegWrite <= 0; writeReg and writeData hold their previous values.
- wb_valid with wb_reg==0 is dropped and does not block a FIFO pop that cycle.
- Push and pop may occur in the same cycle:
  - count is unchanged;
  - when full, push is refused (lu_ready=0) even if a pop occurs that cycle.
- Push into an empty FIFO is not popped in the same cycle.
- Pointers wrap modulo DEPTH; fifo_count ranges 0..DEPTH.
- Scoreboard:
  - Set: issue_valid && issue_reg!=0 sets busy_vec[issue_reg] on the next edge.
  - Clear: a FIFO pop with head_reg!=0 clears busy_vec[head_reg] on the same edge the write is registered.
  - Set and clear of the same register in the same cycle: set wins.
  - Issue to an already-busy register leaves it busy; it clears at the first retirement to that register.
  - busy_vec[0] is always 0.
- The FIFO may starve under continuous pipeline writebacks. This is by design: the hazard unit stalls on busy_vec, which eventually creates idle writeback slots.
- At most one register-file write per cycle. RegWrite is never asserted for reg 0.

Test Plan:
- Reset: hold rst 2 cycles, then release with no stimulus.
  -> RegWrite=0, writeReg=0, writeData=0, busy_vec=0, fifo_count=0; lu_ready=0 during reset, 1 after release.
- Pipeline only: wb_valid=1, wb_reg=3, wb_data=0xDEADBEEF for 1 cycle.
  -> Next cycle RegWrite=1, writeReg=3, writeData=0xDEADBEEF; the cycle after, RegWrite=0.
- Long-latency path:
  - stimulus: issue reg 7; 2 cycles later, lu push {7, 0x12345678} with wb idle.
  - required: busy_vec[7]=1 from the cycle after issue; fifo_count=1 for one cycle; RegWrite=1, writeReg=7 two cycles after push; busy_vec[7]=0 on that same edge.
- Priority/starvation:
  - stimulus: push 4 lu entries (regs 1-4); assert wb_valid continuously for 5 cycles.
  - required: lu_ready=0 at count 4; only wb writes appear during those 5 cycles; then 4 FIFO writes in order 1,2,3,4 on consecutive cycles.
- Register 0 handling:
  - stimulus: wb_valid with wb_reg=0 while FIFO holds {5, 0xA}; separately, lu push {0, 0xB}.
  - required: the reg-5 write occurs the next cycle (wb dropped); the reg-0 entry pops with RegWrite=0 and busy_vec unchanged.
- Reset mid-operation and set-wins collision:
  - stimulus: 3 entries queued, then rst for 1 cycle.
  - required: fifo_count=0, busy_vec=0, no writes afterward.
  - stimulus: issue reg 9 in the same cycle reg 9's entry pops.
  - required: busy_vec[9] remains 1.
